// File: rtl/mem_responder.sv
// mem_responder: word-array memory responder with fixed access latency and valid/ready channels
module mem_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_wstrb;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_wstrb;
    logic              access;
    logic              aligned;
    logic [31:0]       mem [2**(ADDR_W-2)];

    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_nxt;

    always_comb
        state_nxt = state == IDLE ? (req_valid ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                    state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) :
                    rsp_ready ? IDLE : RESP;

    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
    end

    // With LATENCY = 1 the access happens on the acceptance edge, straight from the request inputs
    assign access    = (state == IDLE && req_valid && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    assign acc_we    = state == IDLE ? req_we    : lat_we;
    assign acc_addr  = state == IDLE ? req_addr  : lat_addr;
    assign acc_wdata = state == IDLE ? req_wdata : lat_wdata;
    assign acc_wstrb = state == IDLE ? req_wstrb : lat_wstrb;
    assign aligned   = acc_addr[1:0] == 2'b00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cnt       <= 4'(LATENCY - 1);
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= aligned && !acc_we ? mem[acc_addr[ADDR_W-1:2]] : '0;
                rsp_err   <= !aligned;
            end else if (rsp_valid && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk)
        if (rst && access && aligned && acc_we)
            for (int i = 0; i < 4; i++)
                if (acc_wstrb[i])
                    mem[acc_addr[ADDR_W-1:2]][8*i +: 8] <= acc_wdata[8*i +: 8];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: vector table plus timing sequences for mem_responder at LATENCY 2, 4 and 1
module tb_mem_responder;
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_ready = 1'b1;
    logic        rdy [3];
    logic        vld [3];
    logic [31:0] rd  [3];
    logic        er  [3];
    logic        s_rdy, s_vld, s_er;
    logic [31:0] s_rd;
    int          sel = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        sbe;
    vec_t        vecs[12];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(16), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(vld[0]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0]));
    mem_responder #(.ADDR_W(16), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(vld[1]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1]));
    mem_responder #(.ADDR_W(16), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(vld[2]),
        .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(er[2]));

    always_comb begin
        s_rdy = rdy[sel];
        s_vld = vld[sel];
        s_rd  = rd[sel];
        s_er  = er[sel];
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Scoreboard: each handshaken response is compared with the oldest pushed expectation
    always @(negedge clk)
        if (rst && s_vld && rsp_ready) begin
            if (sb.size() == 0) fail_now("unexpected_rsp");
            else begin
                sbe = sb.pop_front();
                check("rsp_rdata", s_rd, sbe.rdata);
                check("rsp_err", {31'b0, s_er}, {31'b0, sbe.err});
            end
        end

    task automatic check_reset_outputs(input string nm);
        check({nm, "_req_ready"}, {31'b0, s_rdy}, 1);
        check({nm, "_rsp_valid"}, {31'b0, s_vld}, 0);
        check({nm, "_rsp_rdata"}, s_rd, 0);
        check({nm, "_rsp_err"}, {31'b0, s_er}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("reset");
    endtask

    task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_wstrb = s;
        @(negedge clk);
        while (!s_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_rdy) fail_now("accept_timeout");
        else sb.push_back('{exp_rd, exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !s_rdy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !s_rdy) fail_now("idle_timeout");
    endtask

    task automatic timed_read(input logic [15:0] a, input logic [31:0] exp_rd, input int lat);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = a;
        req_wdata = '0;
        req_wstrb = '0;
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 0) sb.push_back('{exp_rd, 1'b0});
            check($sformatf("lat%0d_req_ready_c%0d", lat, c), {31'b0, s_rdy}, (c == 0 || c == lat + 1) ? 1 : 0);
            check($sformatf("lat%0d_rsp_valid_c%0d", lat, c), {31'b0, s_vld}, (c == lat) ? 1 : 0);
            if (c == 0) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0000_0000, 4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 16'h0010, 32'h00AA0000, 4'h4, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 16'h0010, 32'h0000_0000, 4'h0, 32'hDEAABEEF, 1'b0};
        vecs[4]  = '{1'b1, 16'h0012, 32'h12345678, 4'hF, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 16'h0010, 32'h0000_0000, 4'h0, 32'hDEAABEEF, 1'b0};
        vecs[6]  = '{1'b1, 16'h0014, 32'h11223344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 16'h0014, 32'hFFFFFFFF, 4'h0, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 16'h0014, 32'h0000_0000, 4'h0, 32'h11223344, 1'b0};
        vecs[9]  = '{1'b1, 16'h0014, 32'h55667788, 4'h3, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 16'h0014, 32'h0000_0000, 4'h0, 32'h11227788, 1'b0};
        vecs[11] = '{1'b0, 16'h0013, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};

        sel = 0;
        repeat (3) @(posedge clk);
        do_reset();
        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].rdata, vecs[i].err);
            wait_idle();
        end
        timed_read(16'h0010, 32'hDEAABEEF, 2);
        wait_idle();

        rsp_ready = 1'b0;
        do_req(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0);
        n = 0;
        while (!s_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid_rise", {31'b0, s_vld}, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid = (i % 2) == 0;
            req_we = 1'b1;
            req_addr = 16'h0010;
            req_wdata = 32'h0;
            req_wstrb = 4'hF;
            @(negedge clk);
            check("bp_rsp_valid", {31'b0, s_vld}, 1);
            check("bp_rsp_rdata", s_rd, 32'hDEAABEEF);
            check("bp_req_ready", {31'b0, s_rdy}, 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'b0, s_vld}, 1);
        @(negedge clk);
        check("bp_after_valid", {31'b0, s_vld}, 0);
        check("bp_after_ready", {31'b0, s_rdy}, 1);
        do_req(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0);
        wait_idle();

        sel = 1;
        do_reset();
        do_req(1'b1, 16'h0020, 32'h0, 4'hF, 32'h0, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_addr = 16'h0020;
        req_wdata = 32'h11111111;
        req_wstrb = 4'hF;
        @(negedge clk);
        check("abort_c0_ready", {31'b0, s_rdy}, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_c1_ready", {31'b0, s_rdy}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        timed_read(16'h0020, 32'h0, 4);
        wait_idle();

        sel = 2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 16'h0040 + 16'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 32'h0, 1'b0);
            wait_idle();
        end
        timed_read(16'h0044, 32'hA000_0001, 1);
        wait_idle();
        k = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 16'h0040;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("stream_req_ready_c%0d", c), {31'b0, s_rdy}, (c % 2 == 0) ? 1 : 0);
            check($sformatf("stream_rsp_valid_c%0d", c), {31'b0, s_vld}, (c % 2 == 1) ? 1 : 0);
            check($sformatf("stream_overlap_c%0d", c), {31'b0, s_vld && s_rdy}, 0);
            if (s_rdy && req_valid) begin
                sb.push_back('{32'hA000_0000 + 32'(k), 1'b0});
                k++;
                @(posedge clk); #1;
                if (k == 4) req_valid = 1'b0;
                else req_addr = 16'h0040 + 16'(4 * k);
            end
        end
        wait_idle();
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
